// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  localparam int          MD_ITER = 32;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/multdiv_divider.sv
// Non-restoring unsigned divide datapath: one quotient bit per step, MSB first.
// Produces the quotient including the current step so the caller can capture it on the final edge.
module multdiv_divider #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient_next,
  output logic         divisor_zero
);

  // Two extra bits keep the doubled partial remainder signed even when the divisor magnitude is 2^(W-1).
  logic [W+1:0] rem_q, rem_d;
  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] dvs_q, dvs_d;
  logic [W+1:0] shifted;
  logic [W+1:0] stepped;

  always_comb begin
    shifted = {rem_q[W:0], quo_q[W-1]};
    if (rem_q[W+1]) begin
      stepped = shifted + {2'b00, dvs_q};
    end else begin
      stepped = shifted - {2'b00, dvs_q};
    end
    quotient_next = {quo_q[W-2:0], ~stepped[W+1]};
    divisor_zero  = (dvs_q == '0);

    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (step) begin
      rem_d = stepped;
      quo_d = quotient_next;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit with fixed DATA_WIDTH+1 cycle latency.
// Define MULTDIV_DIV_EN to build the divider; otherwise DIV returns 0 with exception set.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int DATA_WIDTH = MD_ITER
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_MULT,
  input  logic                  ctrl_DIV,
  input  logic [DATA_WIDTH-1:0] data_operandA,
  input  logic [DATA_WIDTH-1:0] data_operandB,
  input  logic [4:0]            ctrl_destReg,
  output logic [DATA_WIDTH-1:0] data_result,
  output logic                  data_exception,
  output logic                  data_resultRDY,
  output logic [4:0]            result_destReg,
  output logic                  busy
);

  localparam int             W         = DATA_WIDTH;
  localparam int             CW        = $clog2(W);
  localparam logic [CW-1:0]  LAST_ITER = CW'(W - 1);

  md_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic           neg_q, neg_d;
  logic [4:0]     tag_q, tag_d;
  logic [W-1:0]   result_q, result_d;
  logic           exc_q, exc_d;
  logic           rdy_q, rdy_d;
  logic [4:0]     dest_q, dest_d;
  logic           busy_q, busy_d;

  logic [W-1:0]   a_mag, b_mag;
  logic [2*W-1:0] acc_step;
  logic [2*W-1:0] prod;
  logic           mul_exc;
  logic [W-1:0]   div_res;
  logic           div_exc;

  assign a_mag    = data_operandA[W-1] ? -data_operandA : data_operandA;
  assign b_mag    = data_operandB[W-1] ? -data_operandB : data_operandB;
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod     = neg_q ? -acc_step : acc_step;
  assign mul_exc  = (prod[2*W-1:W] != {W{prod[W-1]}});

`ifdef MULTDIV_DIV_EN
  logic         div_load;
  logic [W-1:0] quo_next;
  logic         div_by_zero;

  assign div_load = ((state_q == IDLE) || (state_q == DONE)) && ctrl_DIV && !ctrl_MULT;

  multdiv_divider #(.W(W)) u_divider (
    .clk          (clock),
    .srst         (ctrl_reset),
    .load         (div_load),
    .step         (state_q == DIV),
    .dividend     (a_mag),
    .divisor      (b_mag),
    .quotient_next(quo_next),
    .divisor_zero (div_by_zero)
  );

  // A positive quotient with the top bit set can only come from INT_MIN / -1.
  always_comb begin
    div_res = neg_q ? -quo_next : quo_next;
    div_exc = div_by_zero || (!neg_q && quo_next[W-1]);
    if (div_by_zero) begin
      div_res = '0;
    end
  end
`else
  assign div_res = '0;
  assign div_exc = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    tag_d    = tag_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    dest_d   = dest_q;
    busy_d   = busy_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (ctrl_MULT || ctrl_DIV) begin
          state_d  = ctrl_MULT ? MUL : DIV;
          busy_d   = 1'b1;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {{W{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = data_operandA[W-1] ^ data_operandB[W-1];
          tag_d    = ctrl_destReg;
        end
      end
      MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d  = DONE;
          busy_d   = 1'b0;
          rdy_d    = 1'b1;
          cnt_d    = '0;
          result_d = prod[W-1:0];
          exc_d    = mul_exc;
          dest_d   = tag_q;
        end
      end
      DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d  = DONE;
          busy_d   = 1'b0;
          rdy_d    = 1'b1;
          cnt_d    = '0;
          result_d = div_res;
          exc_d    = div_exc;
          dest_d   = tag_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      tag_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      dest_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      tag_q    <= tag_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      dest_q   <= dest_d;
      busy_q   <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign result_destReg = dest_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: stimulus pushes expected results, a monitor checks each RDY pulse.
// Divide expectations follow the MULTDIV_DIV_EN build option.
module tb_multdiv_unit;
  import multdiv_pkg::*;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [4:0]  ctrl_destReg;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic [4:0]  result_destReg;
  logic        busy;

  multdiv_unit dut (
    .clock         (clock),
    .ctrl_reset    (ctrl_reset),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .ctrl_destReg  (ctrl_destReg),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .result_destReg(result_destReg),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    logic [4:0]  tag;
    int          when;
  } exp_t;

  typedef struct {
    logic        mul;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[13];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every RDY pulse must match the oldest outstanding expectation, including its cycle.
  always @(negedge clock) begin
    if (data_resultRDY === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rdy: got result %h tag %0d want no pulse (cycle %0d)",
                 data_result, result_destReg, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn tag=%0d result=%h exc=%0b cycle=%0d", result_destReg, data_result,
                 data_exception, cyc);
        chk("result", data_result, e.res);
        chk("exception", {31'b0, data_exception}, {31'b0, e.exc});
        chk("dest_reg", {27'b0, result_destReg}, {27'b0, e.tag});
        chk("rdy_cycle", cyc, e.when);
      end
    end
  end

  // Caller is just after a rising edge; inputs are held for exactly one sampling edge.
  task automatic start_op(input logic mul, input logic div, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input logic push,
                          input logic [31:0] er, input logic ee, output int t);
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    data_operandA = a;
    data_operandB = b;
    ctrl_destReg  = tag;
    t             = cyc;
    if (push) sb.push_back('{er, ee, tag, cyc + 33});
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    ctrl_destReg  = 5'($urandom);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk_reset_outputs(input string tagname);
    chk({tagname, "_result"}, data_result, 32'h0);
    chk({tagname, "_exc"}, {31'b0, data_exception}, 32'h0);
    chk({tagname, "_rdy"}, {31'b0, data_resultRDY}, 32'h0);
    chk({tagname, "_dest"}, {27'b0, result_destReg}, 32'h0);
    chk({tagname, "_busy"}, {31'b0, busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, t2;
    ctrl_reset    = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    ctrl_destReg  = '0;

    vecs[0]  = '{1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
    vecs[1]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[2]  = '{1'b1, INT_MIN,       32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[3]  = '{1'b1, INT_MIN,       32'h0000_0001, 32'h8000_0000, 1'b0};
    vecs[4]  = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1};
    vecs[5]  = '{1'b1, 32'hFFFF_CFC7, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b0, 32'hFFFF_FFD5, 32'h0000_0005, 32'hFFFF_FFF8, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b0, INT_MIN,       32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
    vecs[10] = '{1'b0, INT_MIN,       32'h0000_0001, 32'h8000_0000, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_0007, 32'h0000_0009, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_000A, 32'h0000_0002, 32'h0000_0005, 1'b0};

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_reset_outputs("reset");
    @(posedge clock);
    #1;
    ctrl_reset = 1'b0;

    // 7 * -6 with busy window checks
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 5'd5, 1'b1, 32'hFFFF_FFD6, 1'b0, t);
    @(negedge clock);
    chk("busy_first", {31'b0, busy}, 32'h1);
    repeat (31) @(negedge clock);
    chk("busy_last", {31'b0, busy}, 32'h1);
    @(negedge clock);
    chk("busy_done", {31'b0, busy}, 32'h0);
    wait_cyc(t + 34);

    for (int i = 0; i < 13; i++) begin
      logic [31:0] er;
      logic        ee;
      er = vecs[i].res;
      ee = vecs[i].exc;
`ifndef MULTDIV_DIV_EN
      if (!vecs[i].mul) begin
        er = 32'h0;
        ee = 1'b1;
      end
`endif
      start_op(vecs[i].mul, !vecs[i].mul, vecs[i].a, vecs[i].b, 5'(10 + i), 1'b1, er, ee, t);
      wait_cyc(t + 34);
    end

    // Both starts high: multiply wins.
    start_op(1'b1, 1'b1, 32'd6, 32'd7, 5'd9, 1'b1, 32'd42, 1'b0, t);
    wait_cyc(t + 34);

    // DIV pulse while busy is ignored; a start during DONE is accepted.
    start_op(1'b1, 1'b0, 32'd3, 32'd4, 5'd3, 1'b1, 32'd12, 1'b0, t);
    wait_cyc(t + 10);
    ctrl_DIV = 1'b1;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    wait_cyc(t + 33);
    start_op(1'b1, 1'b0, 32'd5, 32'd6, 5'd4, 1'b1, 32'd30, 1'b0, t2);
    chk("b2b_start_cycle", t2, t + 33);
    wait_cyc(t2 + 34);

    // Reset mid-operation discards the partial result.
    start_op(1'b1, 1'b0, 32'd9, 32'd9, 5'd2, 1'b0, 32'd0, 1'b0, t);
    wait_cyc(t + 10);
    ctrl_reset = 1'b1;
    @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    @(negedge clock);
    chk_reset_outputs("midop");

    // Reset wins over a simultaneous start.
    @(posedge clock);
    #1;
    ctrl_reset = 1'b1;
    ctrl_MULT  = 1'b1;
    @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    ctrl_MULT  = 1'b0;
    @(negedge clock);
    chk("reset_prio_busy", {31'b0, busy}, 32'h0);
    repeat (40) @(posedge clock);
    #1;

    start_op(1'b1, 1'b0, 32'd2, 32'd3, 5'd6, 1'b1, 32'd6, 1'b0, t);
    wait_cyc(t + 40);
    @(negedge clock);
    chk("hold_result", data_result, 32'd6);
    chk("hold_dest", {27'b0, result_destReg}, 32'd6);

    chk("pending_results", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
